// File: rtl/par2serial_8_1_if.sv
// Byte-lane to serial-lane bundle between the upstream 32-to-8 demux
// and the serializer. The byte side (data_in/valid_in) is driven by
// the master. The serial side (data_out/valid_out/sync_out) is driven
// by the slave.
interface par2serial_8_1_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             data_out;
  logic             valid_out;
  logic             sync_out;

  // Upstream byte source, which also observes the serial stream.
  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  valid_out,
    input  sync_out
  );

  // Serializer.
  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output valid_out,
    output sync_out
  );
endinterface

// File: rtl/par2serial_8_1.sv
// 8:1 parallel-to-serial converter.
// The converter takes one byte every eight clk_32f cycles, at the edge
// where the bit counter sits at its last value (the load edge). It then
// shifts that byte out MSB-first with no gap between bytes. When
// valid_in is low at a load edge, the IDLE comma byte is sent in its
// place, so the line always carries a symbol. sync_out marks the MSB
// of every byte on the line. valid_out carries the valid flag of the
// byte currently on data_out.
module par2serial_8_1 #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] IDLE  = 8'hBC
) (
  input logic              clk_32f,
  input logic              reset,
  par2serial_8_1_if.slave  bus
);

  localparam int          CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             vflag;
  logic [CW-1:0]    bit_idx;
  logic             load;

  // Bit selector that walks from the MSB down to the LSB as cnt advances.
  always_comb begin
    bit_idx = LAST - cnt;
    load    = (cnt == LAST);
  end

  // Counter, byte holding register and registered serial outputs.
  // Every term uses the pre-edge state. A load edge therefore still
  // emits the old byte's LSB while it captures the next byte, which
  // keeps the stream gapless. Reset has priority over a load edge, so
  // a byte that is partly shifted out is dropped.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      cnt           <= '0;
      shreg         <= IDLE;
      vflag         <= 1'b0;
      bus.data_out  <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.sync_out  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every right-hand side below
      // read the pre-edge value. Blocking assignments would let data_out
      // see the freshly loaded byte or the advanced counter.
      cnt           <= cnt + 1'b1;
      bus.data_out  <= shreg[bit_idx];
      bus.valid_out <= vflag;
      bus.sync_out  <= (cnt == '0);
      if (load) begin
        shreg <= bus.valid_in ? bus.data_in : IDLE;
        vflag <= bus.valid_in;
      end
    end
  end

endmodule

// File: tb/tb_par2serial_8_1.sv
// Self-checking bench for par2serial_8_1.
// The reference model works on byte slots. After reset, slot 0 is IDLE
// with valid low. Every 8th non-reset edge captures the next slot.
// Output bit k of a slot appears after the (8*s + k + 1)-th non-reset
// edge. Directed bytes are checked against hand-written literal values.
module tb_par2serial_8_1;
  localparam int         WIDTH = 8;
  localparam logic [7:0] IDLE  = 8'hBC;

  logic clk_32f = 1'b0;
  logic reset;

  par2serial_8_1_if #(.WIDTH(WIDTH)) bus ();

  par2serial_8_1 #(.WIDTH(WIDTH), .IDLE(IDLE)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  int         g = 0;        // every posedge since time 0
  int         n = 0;        // non-reset posedges since last reset
  logic [7:0] cur_byte;
  logic       cur_valid;
  logic [8:0] slot_q[$];
  logic [2:0] exp_o;        // {data, valid, sync}
  bit         model_live = 0;

  logic obs_d [0:4095];
  logic obs_v [0:4095];
  logic obs_s [0:4095];

  always @(posedge clk_32f) begin
    int pos;
    g = g + 1;
    if (reset) begin
      n = 0;
      slot_q.delete();
      cur_byte  = IDLE;
      cur_valid = 1'b0;
      exp_o     = 3'b000;
    end else begin
      n   = n + 1;
      pos = (n - 1) % 8;
      if (pos == 0 && n > 1) begin
        if (slot_q.size() > 0) {cur_valid, cur_byte} = slot_q.pop_front();
      end
      exp_o = {cur_byte[3'(WIDTH - 1 - pos)], cur_valid, (pos == 0)};
      if (n % 8 == 0)
        slot_q.push_back(bus.valid_in ? {1'b1, bus.data_in} : {1'b0, IDLE});
    end
    model_live = 1;
  end

  // Compare the DUT against the model on every cycle, away from the active edge.
  always @(negedge clk_32f) begin
    if (model_live) begin
      if (g < 4096) begin
        obs_d[g] = bus.data_out;
        obs_v[g] = bus.valid_out;
        obs_s[g] = bus.sync_out;
      end
      vectors = vectors + 1;
      if ({bus.data_out, bus.valid_out, bus.sync_out} !== exp_o) begin
        miscompares = miscompares + 1;
        $display("FAIL stream@edge%0d: dut d/v/s=%b%b%b required %b",
                 g, bus.data_out, bus.valid_out, bus.sync_out, exp_o);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors = vectors + 1;
    if (act !== req) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Byte seen on the line after edges s+1 .. s+8, MSB first.
  function automatic logic [7:0] obs_byte(input int s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = obs_d[s+1+i];
    return r;
  endfunction

  function automatic logic [7:0] obs_vbyte(input int s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = obs_v[s+1+i];
    return r;
  endfunction

  function automatic logic [7:0] obs_sbyte(input int s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = obs_s[s+1+i];
    return r;
  endfunction

  // Present a byte so that the next load edge takes it. Return that
  // load edge's index. Afterwards, scribble on the inputs, because
  // they must be ignored until the next load edge.
  task automatic send_byte(input logic [7:0] d, input logic v, output int load_g);
    int k;
    for (k = 0; k < 32 && !(n % 8 == 7 && !reset); k++) @(negedge clk_32f);
    if (!(n % 8 == 7 && !reset)) begin
      vectors     = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL send_wait: load slot not reached, n=%0d", n);
    end
    bus.data_in  = d;
    bus.valid_in = v;
    @(negedge clk_32f);
    load_g       = g;
    bus.data_in  = 8'($urandom);
    bus.valid_in = 1'($urandom);
  endtask

  // ---------------- stimulus ----------------
  int r1, r2;
  int l1, l2, l3, l4, l5, l6, l7, l8, l9, l10, l11, l12;

  initial begin
    reset        = 1'b1;
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b0;
    repeat (3) @(negedge clk_32f);
    check("reset_outputs", {29'd0, bus.data_out, bus.valid_out, bus.sync_out}, 32'd0);

    reset = 1'b0;
    r1    = g;
    send_byte(8'hA5, 1'b1, l1);
    send_byte(8'hFF, 1'b1, l2);
    send_byte(8'h00, 1'b1, l3);
    send_byte(8'h3C, 1'b1, l4);
    send_byte(8'h77, 1'b0, l5);
    repeat (3) @(negedge clk_32f);
    bus.data_in  = 8'h11;
    bus.valid_in = 1'b1;

    // Abort a byte with reset after three of its bits have gone out.
    send_byte(8'hA5, 1'b1, l6);
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
    @(negedge clk_32f);
    check("abort_outputs", {29'd0, bus.data_out, bus.valid_out, bus.sync_out}, 32'd0);
    @(negedge clk_32f);
    reset = 1'b0;
    r2    = g;

    // Bytes in the upstream demux lane order for 32'hDEADBEEF.
    send_byte(8'hEF, 1'b1, l7);
    send_byte(8'hBE, 1'b1, l8);
    send_byte(8'hAD, 1'b1, l9);
    send_byte(8'hDE, 1'b1, l10);
    send_byte(8'h77, 1'b0, l11);
    send_byte(8'h77, 1'b0, l12);
    bus.valid_in = 1'b0;
    repeat (10) @(negedge clk_32f);

    // Literal expectations.
    check("post_reset_idle_bits",  {24'd0, obs_byte(r1)},  32'h0000_00BC);
    check("post_reset_idle_valid", {24'd0, obs_vbyte(r1)}, 32'h0000_0000);
    check("post_reset_idle_sync",  {24'd0, obs_sbyte(r1)}, 32'h0000_0080);
    check("a5_bits",  {24'd0, obs_byte(l1)},  32'h0000_00A5);
    check("a5_valid", {24'd0, obs_vbyte(l1)}, 32'h0000_00FF);
    check("a5_sync",  {24'd0, obs_sbyte(l1)}, 32'h0000_0080);
    check("b2b_bits", {8'd0, obs_byte(l2), obs_byte(l3), obs_byte(l4)}, 32'h00FF_003C);
    check("b2b_sync", {8'd0, obs_sbyte(l2), obs_sbyte(l3), obs_sbyte(l4)}, 32'h0080_8080);
    check("b2b_gap1", l3 - l2, 32'd8);
    check("b2b_gap2", l4 - l3, 32'd8);
    check("invalid_77_bits",  {24'd0, obs_byte(l5)},  32'h0000_00BC);
    check("invalid_77_valid", {24'd0, obs_vbyte(l5)}, 32'h0000_0000);
    check("abort_partial", {29'd0, obs_d[l6+1], obs_d[l6+2], obs_d[l6+3]}, 32'd5);
    check("first_load_after_reset", l7 - r2, 32'd8);
    check("chain_bits",  {obs_byte(l7), obs_byte(l8), obs_byte(l9), obs_byte(l10)}, 32'hEFBE_ADDE);
    check("chain_valid", {obs_vbyte(l7), obs_vbyte(l8), obs_vbyte(l9), obs_vbyte(l10)}, 32'hFFFF_FFFF);
    check("chain_idle_bits",  {24'd0, obs_byte(l11)},  32'h0000_00BC);
    check("chain_idle_valid", {24'd0, obs_vbyte(l11)}, 32'h0000_0000);
    check("chain_idle2_bits", {24'd0, obs_byte(l12)},  32'h0000_00BC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
